// File: rtl/pe_lin_pkg.sv
// Shared constants for the PE_Lin sequencer: default widths, lane count and
// FSM state encodings.
package pe_lin_pkg;

    localparam int DW_DEF    = 8;
    localparam int OW_DEF    = 12;
    localparam int LEN_W_DEF = 8;
    localparam int NLANE     = 4;

    typedef logic [2:0] state_t;

    localparam state_t IDLE   = 3'd0;
    localparam state_t CLEAR  = 3'd1;
    localparam state_t STREAM = 3'd2;
    localparam state_t DRAIN  = 3'd3;
    localparam state_t DONE   = 3'd4;

endpackage

// File: rtl/pe_lin_ctrl_if.sv
// Job, activation and result handshakes between the job source and the
// PE_Lin sequencer; the source/sink side is master, the controller is slave.
interface pe_lin_ctrl_if
    import pe_lin_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int OW    = OW_DEF,
    parameter int LEN_W = LEN_W_DEF
) ();

    logic                  cfg_valid;
    logic                  cfg_ready;
    logic [NLANE*DW-1:0]   cfg_w;
    logic [LEN_W-1:0]      cfg_len;

    logic                  act_valid;
    logic                  act_ready;
    logic [DW-1:0]         act_data;

    logic                  res_valid;
    logic                  res_ready;
    logic [NLANE*OW-1:0]   res_data;

    modport master (
        output cfg_valid, cfg_w, cfg_len,
        output act_valid, act_data,
        output res_ready,
        input  cfg_ready, act_ready,
        input  res_valid, res_data
    );

    modport slave (
        input  cfg_valid, cfg_w, cfg_len,
        input  act_valid, act_data,
        input  res_ready,
        output cfg_ready, act_ready,
        output res_valid, res_data
    );

endinterface

// File: rtl/pe_lin_ctrl.sv
// Sequencer for the 4-lane linear PE array: clear, stream N activations with
// fire gating, drain the PE pipeline, then hold the captured outputs.
module pe_lin_ctrl
    import pe_lin_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int OW    = OW_DEF,
    parameter int LEN_W = LEN_W_DEF,
    parameter int LAT   = 1
) (
    input  logic           clk,
    input  logic           rstn,
    pe_lin_ctrl_if.slave   bus,
    input  logic           abort,
    output logic           pe_rstn,
    output logic           pe_fire,
    output logic [DW-1:0]  pe_w1,
    output logic [DW-1:0]  pe_w2,
    output logic [DW-1:0]  pe_w3,
    output logic [DW-1:0]  pe_w4,
    output logic [DW-1:0]  pe_a,
    input  logic [OW-1:0]  pe_o1,
    input  logic [OW-1:0]  pe_o2,
    input  logic [OW-1:0]  pe_o3,
    input  logic [OW-1:0]  pe_o4,
    output logic           busy
);

    localparam int LAT_W = (LAT < 2) ? 1 : $clog2(LAT + 1);

    state_t               state_q,     state_d;
    logic [LEN_W-1:0]     rem_q,       rem_d;
    logic [LAT_W-1:0]     drain_q,     drain_d;
    logic [NLANE*DW-1:0]  w_q,         w_d;
    logic                 cfg_ready_q, cfg_ready_d;
    logic                 act_ready_q, act_ready_d;
    logic                 pe_rstn_q,   pe_rstn_d;
    logic                 pe_fire_q,   pe_fire_d;
    logic [DW-1:0]        pe_a_q,      pe_a_d;
    logic                 res_valid_q, res_valid_d;
    logic [NLANE*OW-1:0]  res_data_q,  res_data_d;
    logic                 busy_q,      busy_d;

    logic cfg_hs;
    logic act_hs;
    logic res_hs;

    assign cfg_hs = cfg_ready_q & bus.cfg_valid;
    assign act_hs = act_ready_q & bus.act_valid;
    assign res_hs = res_valid_q & bus.res_ready;

    always_comb begin
        // NOTE: every _d starts from its _q (or its idle value) so no path through the case infers a latch.
        state_d     = state_q;
        rem_d       = rem_q;
        drain_d     = drain_q;
        w_d         = w_q;
        cfg_ready_d = cfg_ready_q;
        act_ready_d = act_ready_q;
        pe_rstn_d   = 1'b1;
        pe_fire_d   = 1'b0;
        pe_a_d      = '0;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;

        case (state_q)
            IDLE: begin
                if (cfg_hs) begin
                    w_d         = bus.cfg_w;
                    rem_d       = bus.cfg_len;
                    cfg_ready_d = 1'b0;
                    pe_rstn_d   = 1'b0;
                    state_d     = CLEAR;
                end
            end

            CLEAR: begin
                if (rem_q == '0) begin
                    drain_d = LAT_W'(LAT);
                    state_d = DRAIN;
                end else begin
                    act_ready_d = 1'b1;
                    state_d     = STREAM;
                end
            end

            STREAM: begin
                // A stall bubble leaves fire/a at their idle defaults and rem untouched.
                if (act_hs) begin
                    pe_fire_d = 1'b1;
                    pe_a_d    = bus.act_data;
                    rem_d     = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        act_ready_d = 1'b0;
                        drain_d     = LAT_W'(LAT);
                        state_d     = DRAIN;
                    end
                end
            end

            DRAIN: begin
                if (drain_q == '0) begin
                    res_data_d  = {pe_o4, pe_o3, pe_o2, pe_o1};
                    res_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    drain_d = drain_q - LAT_W'(1);
                end
            end

            DONE: begin
                if (res_hs) begin
                    res_valid_d = 1'b0;
                    cfg_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end

            default: begin
                act_ready_d = 1'b0;
                res_valid_d = 1'b0;
                cfg_ready_d = 1'b1;
                state_d     = IDLE;
            end
        endcase

        // Abort overrides every handshake above; the PE keeps its partial sums until the next CLEAR.
        if (abort && (state_q != IDLE)) begin
            state_d     = IDLE;
            pe_fire_d   = 1'b0;
            pe_a_d      = '0;
            pe_rstn_d   = 1'b1;
            act_ready_d = 1'b0;
            res_valid_d = 1'b0;
            cfg_ready_d = 1'b1;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            drain_q     <= '0;
            w_q         <= '0;
            cfg_ready_q <= 1'b1;
            act_ready_q <= 1'b0;
            pe_rstn_q   <= 1'b0;
            pe_fire_q   <= 1'b0;
            pe_a_q      <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so all flops update from pre-edge values.
            state_q     <= state_d;
            rem_q       <= rem_d;
            drain_q     <= drain_d;
            w_q         <= w_d;
            cfg_ready_q <= cfg_ready_d;
            act_ready_q <= act_ready_d;
            pe_rstn_q   <= pe_rstn_d;
            pe_fire_q   <= pe_fire_d;
            pe_a_q      <= pe_a_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.cfg_ready = cfg_ready_q;
    assign bus.act_ready = act_ready_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;

    assign pe_rstn = pe_rstn_q;
    assign pe_fire = pe_fire_q;
    assign pe_a    = pe_a_q;
    assign pe_w1   = w_q[0*DW +: DW];
    assign pe_w2   = w_q[1*DW +: DW];
    assign pe_w3   = w_q[2*DW +: DW];
    assign pe_w4   = w_q[3*DW +: DW];
    assign busy    = busy_q;

endmodule
